// File: rtl/memory_cycle.sv
// Memory stage: issues loads/stores over a request/acknowledge data port,
// stalls the front of the pipeline while an access is outstanding, aborts
// accesses that run past TIMEOUT wait cycles, and registers results into
// the memory->writeback pipeline register.
module memory_cycle #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic            ResultSrcM,
    input  logic [4:0]      RD_M,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] ALU_ResultM,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            StallM,
    output logic            MemErrM,
    output logic            RegWriteW,
    output logic            ResultSrcW,
    output logic [4:0]      RD_W,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW
);

    typedef enum logic {IDLE, WAIT} state_t;

    // Last WAIT cycle index; an unacknowledged request aborts here.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       memop;
    logic       abort;

    assign memop     = MemWriteM | ResultSrcM;
    assign mem_we    = MemWriteM;
    assign mem_addr  = ALU_ResultM;
    assign mem_wdata = WriteDataM;
    // An ack arriving on the timeout cycle wins, so abort already excludes it.
    assign StallM    = memop & ~mem_ack & ~abort;

    // Next-state, wait counter and request generation.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_req      = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                mem_req = memop;
                if (memop && !mem_ack) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = 8'd0;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == LAST_WAIT) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
                mem_req = ~abort;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            MemErrM  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (abort)
                MemErrM <= 1'b1;
        end
    end

    // M->W pipeline register: bubble while stalled, squashed capture on abort.
    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= 5'd0;
            PCPlus4W    <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
        end else if (StallM) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
        end else begin
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            if (abort) begin
                RegWriteW  <= 1'b0;
                ResultSrcW <= 1'b0;
                ReadDataW  <= '0;
            end else begin
                RegWriteW  <= RegWriteM;
                ResultSrcW <= ResultSrcM;
                ReadDataW  <= ResultSrcM ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: a vector table of single-cycle accesses
// plus hand-written multi-cycle sequences (wait states, timeout, late ack,
// reset while waiting).
module tb_memory_cycle;

    localparam int XLEN = 64;
    localparam int TO   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]      RD_M;
    logic [XLEN-1:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic            mem_req, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            StallM, MemErrM;
    logic            RegWriteW, ResultSrcW;
    logic [4:0]      RD_W;
    logic [XLEN-1:0] PCPlus4W, ALU_ResultW, ReadDataW;

    int checks = 0;
    int errors = 0;

    memory_cycle #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .StallM(StallM), .MemErrM(MemErrM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        regw, memw, rsrc;
        logic [4:0]  rd;
        logic [63:0] pc, wd, alu;
        logic        ack;
        logic [63:0] rdata;
        logic        x_req, x_we, x_stall;
        logic        x_regw, x_rsrcw;
        logic [4:0]  x_rdw;
        logic [63:0] x_pcw, x_aluw, x_rdataw;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic regw, input logic memw, input logic rsrc,
                          input logic [4:0] rd, input logic [63:0] pc,
                          input logic [63:0] wd, input logic [63:0] alu,
                          input logic ack, input logic [63:0] rdata);
        RegWriteM   = regw;
        MemWriteM   = memw;
        ResultSrcM  = rsrc;
        RD_M        = rd;
        PCPlus4M    = pc;
        WriteDataM  = wd;
        ALU_ResultM = alu;
        mem_ack     = ack;
        mem_rdata   = rdata;
    endtask

    task automatic nop();
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b0, 64'h0);
    endtask

    initial begin
        // {regw,memw,rsrc,rd,pc,wd,alu,ack,rdata, req,we,stall, regw,rsrcw,rdw,pcw,aluw,rdataw}
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd5, 64'h1004, 64'h0, 64'h2A, 1'b0, 64'h0,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 64'h1004, 64'h2A, 64'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 5'd10, 64'h1008, 64'h0, 64'h100, 1'b1, 64'hDEADBEEF_CAFEF00D,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 64'h1008, 64'h100, 64'hDEADBEEF_CAFEF00D};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 5'd0, 64'h100C, 64'h77, 64'h200, 1'b1, 64'h1234,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'h100C, 64'h200, 64'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 5'd12, 64'h1010, 64'h0, 64'h33, 1'b1, 64'hFF,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd12, 64'h1010, 64'h33, 64'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 5'd3, 64'h2000, 64'h0, 64'h108, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 64'h2000, 64'h108, 64'hFFFF_FFFF_FFFF_FFFF};

        // Reset with random inputs.
        rst = 1'b0;
        set_in(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom), {$urandom, $urandom});
        tick();
        chk("rst_regw",  RegWriteW, 0);
        chk("rst_rsrcw", ResultSrcW, 0);
        chk("rst_rdw",   RD_W, 0);
        chk("rst_pcw",   PCPlus4W, 0);
        chk("rst_aluw",  ALU_ResultW, 0);
        chk("rst_rdataw", ReadDataW, 0);
        chk("rst_err",   MemErrM, 0);
        rst = 1'b1;

        // Single-cycle vectors, all completing in the issue cycle.
        for (int i = 0; i < 5; i++) begin
            set_in(vecs[i].regw, vecs[i].memw, vecs[i].rsrc, vecs[i].rd, vecs[i].pc,
                   vecs[i].wd, vecs[i].alu, vecs[i].ack, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d_req", i),   mem_req, vecs[i].x_req);
            if (vecs[i].x_req) begin
                chk($sformatf("v%0d_we", i),    mem_we, vecs[i].x_we);
                chk($sformatf("v%0d_addr", i),  mem_addr, vecs[i].alu);
                chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wd);
            end
            chk($sformatf("v%0d_stall", i), StallM, vecs[i].x_stall);
            tick();
            chk($sformatf("v%0d_regw", i),   RegWriteW, vecs[i].x_regw);
            chk($sformatf("v%0d_rsrcw", i),  ResultSrcW, vecs[i].x_rsrcw);
            chk($sformatf("v%0d_rdw", i),    RD_W, vecs[i].x_rdw);
            chk($sformatf("v%0d_pcw", i),    PCPlus4W, vecs[i].x_pcw);
            chk($sformatf("v%0d_aluw", i),   ALU_ResultW, vecs[i].x_aluw);
            chk($sformatf("v%0d_rdataw", i), ReadDataW, vecs[i].x_rdataw);
        end

        // Store acknowledged in its third cycle; W holds bubbles meanwhile.
        set_in(1'b0, 1'b1, 1'b0, 5'd7, 64'h3004, 64'h55, 64'h300, 1'b0, 64'h0);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) mem_ack = 1'b1;
            #1;
            chk($sformatf("st_c%0d_req", c),   mem_req, 1);
            chk($sformatf("st_c%0d_we", c),    mem_we, 1);
            chk($sformatf("st_c%0d_wdata", c), mem_wdata, 64'h55);
            chk($sformatf("st_c%0d_stall", c), StallM, (c < 3) ? 1 : 0);
            tick();
            chk($sformatf("st_c%0d_regw", c), RegWriteW, 0);
            chk($sformatf("st_c%0d_rsrcw", c), ResultSrcW, 0);
            if (c < 3) begin
                chk($sformatf("st_c%0d_rdw_hold", c), RD_W, 5'd3);
                chk($sformatf("st_c%0d_rdata_hold", c), ReadDataW, 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        chk("st_rdataw", ReadDataW, 0);
        chk("st_aluw", ALU_ResultW, 64'h300);
        chk("st_rdw", RD_W, 5'd7);
        nop();

        // Load acked in the would-be abort cycle: ack wins.
        set_in(1'b1, 1'b0, 1'b1, 5'd4, 64'h4004, 64'h0, 64'h500, 1'b0, 64'h0);
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) begin
                mem_ack   = 1'b1;
                mem_rdata = 64'h7;
            end
            #1;
            chk($sformatf("la_c%0d_req", c), mem_req, 1);
            chk($sformatf("la_c%0d_stall", c), StallM, (c < 5) ? 1 : 0);
            tick();
        end
        chk("la_rdataw", ReadDataW, 64'h7);
        chk("la_regw", RegWriteW, 1);
        chk("la_rsrcw", ResultSrcW, 1);
        chk("la_err", MemErrM, 0);
        nop();

        // Load never acknowledged: abort in cycle TO+1.
        set_in(1'b1, 1'b0, 1'b1, 5'd9, 64'h5004, 64'h0, 64'h400, 1'b0, 64'h0);
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk($sformatf("to_c%0d_req", c), mem_req, (c <= 4) ? 1 : 0);
            chk($sformatf("to_c%0d_stall", c), StallM, (c <= 4) ? 1 : 0);
            tick();
            chk($sformatf("to_c%0d_err", c), MemErrM, (c == 5) ? 1 : 0);
        end
        chk("to_regw", RegWriteW, 0);
        chk("to_rsrcw", ResultSrcW, 0);
        chk("to_rdataw", ReadDataW, 0);
        chk("to_rdw", RD_W, 5'd9);
        chk("to_aluw", ALU_ResultW, 64'h400);
        nop();
        #1;
        chk("to_idle_req", mem_req, 0);
        tick();
        tick();
        chk("to_err_sticky", MemErrM, 1);

        // Reset while a load waits.
        set_in(1'b1, 1'b0, 1'b1, 5'd6, 64'h6004, 64'h0, 64'h600, 1'b0, 64'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rw_regw", RegWriteW, 0);
        chk("rw_rdw", RD_W, 0);
        chk("rw_aluw", ALU_ResultW, 0);
        chk("rw_pcw", PCPlus4W, 0);
        chk("rw_err", MemErrM, 0);
        nop();
        #1;
        chk("rw_idle_req", mem_req, 0);
        chk("rw_idle_stall", StallM, 0);
        set_in(1'b1, 1'b0, 1'b1, 5'd8, 64'h7004, 64'h0, 64'h700, 1'b1, 64'hABC);
        #1;
        chk("rw_new_req", mem_req, 1);
        chk("rw_new_stall", StallM, 0);
        tick();
        chk("rw_new_rdataw", ReadDataW, 64'hABC);
        chk("rw_new_rdw", RD_W, 5'd8);
        nop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
